// File: rtl/sine_sched_pkg.sv
// Shared types, default constants and modular address arithmetic for the
// time-multiplexed three-phase sine LUT scheduler.
package sine_sched_pkg;

    localparam int LUT_DEPTH_DEF = 20000;
    localparam int ADDR_W_DEF    = 15;
    localparam int DATA_W_DEF    = 8;
    localparam int OFFS_B_DEF    = 6667;
    localparam int OFFS_C_DEF    = 13333;

    typedef logic [ADDR_W_DEF-1:0] addr_t;
    typedef logic [ADDR_W_DEF:0]   addr_ext_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ADDR_A = 3'd1,
        ST_ADDR_B = 3'd2,
        ST_ADDR_C = 3'd3,
        ST_COMMIT = 3'd4
    } state_t;

    // Both operands are below LUT_DEPTH, so one conditional subtract is enough.
    function automatic addr_t wrap_add(input addr_t a, input addr_t b);
        addr_ext_t sum_s;
        sum_s = {1'b0, a} + {1'b0, b};
        if (sum_s >= addr_ext_t'(LUT_DEPTH_DEF)) begin
            sum_s = sum_s - addr_ext_t'(LUT_DEPTH_DEF);
        end else begin
            sum_s = sum_s;
        end
        return sum_s[ADDR_W_DEF-1:0];
    endfunction

endpackage

// File: rtl/sine_lut_scheduler_phase_accum.sv
// Phase accumulator: frame step latch with saturation, phase_rst pending flag
// and the base address register advanced once per committed frame.
module phase_accum
    import sine_sched_pkg::*;
#(
    parameter int LUT_DEPTH = LUT_DEPTH_DEF,
    parameter int ADDR_W    = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              commit,
    input  logic              phase_rst,
    input  logic [ADDR_W-1:0] freq_step,
    output logic [ADDR_W-1:0] base
);

    localparam logic [ADDR_W-1:0] STEP_MAX = ADDR_W'(LUT_DEPTH - 1);

    logic [ADDR_W-1:0] step_r;
    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W-1:0] step_sat_s;
    logic [ADDR_W-1:0] next_base_s;
    logic              pend_r;

    // Saturate the step and pick the next base, honouring a same-cycle phase_rst.
    always_comb begin
        step_sat_s  = freq_step;
        next_base_s = base_r;
        if (freq_step >= ADDR_W'(LUT_DEPTH)) begin
            step_sat_s = STEP_MAX;
        end else begin
            step_sat_s = freq_step;
        end
        if (pend_r || phase_rst) begin
            next_base_s = {ADDR_W{1'b0}};
        end else begin
            next_base_s = wrap_add(base_r, step_r);
        end
    end

    // Step is latched at frame start so it stays constant for the whole frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_r <= {ADDR_W{1'b0}};
        end else if (frame_start) begin
            step_r <= step_sat_s;
        end else begin
            step_r <= step_r;
        end
    end

    // Base advances only at commit; that commit also consumes any pending phase reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_r <= {ADDR_W{1'b0}};
            pend_r <= 1'b0;
        end else if (commit) begin
            base_r <= next_base_s;
            pend_r <= 1'b0;
        end else if (phase_rst) begin
            base_r <= base_r;
            pend_r <= 1'b1;
        end else begin
            base_r <= base_r;
            pend_r <= pend_r;
        end
    end

    assign base = base_r;

endmodule

// File: rtl/sine_lut_scheduler.sv
// Time-multiplexes one single-port sine LUT into three 120-degree-spaced
// samples per tick and presents them together on registered outputs.
module sine_lut_scheduler
    import sine_sched_pkg::*;
#(
    parameter int LUT_DEPTH = LUT_DEPTH_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int OFFS_B    = OFFS_B_DEF,
    parameter int OFFS_C    = OFFS_C_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              sample_tick,
    input  logic [ADDR_W-1:0] freq_step,
    input  logic              phase_rst,
    input  logic              ovr_clr,
    output logic [ADDR_W-1:0] lut_addr,
    output logic              lut_rd_en,
    input  logic [DATA_W-1:0] lut_data,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [DATA_W-1:0] out_c,
    output logic              out_valid,
    output logic              busy,
    output logic              overrun
);

    state_t            state_r;
    state_t            next_state_s;
    logic [ADDR_W-1:0] base_s;
    logic [ADDR_W-1:0] addr_b_s;
    logic [ADDR_W-1:0] addr_c_s;
    logic [ADDR_W-1:0] lut_addr_nxt_s;
    logic              lut_rd_en_nxt_s;
    logic              tick_drop_s;
    logic              frame_start_s;
    logic              commit_s;

    logic [ADDR_W-1:0] lut_addr_r;
    logic              lut_rd_en_r;
    logic [DATA_W-1:0] hold_a_r;
    logic [DATA_W-1:0] hold_b_r;
    logic [DATA_W-1:0] out_a_r;
    logic [DATA_W-1:0] out_b_r;
    logic [DATA_W-1:0] out_c_r;
    logic              out_valid_r;
    logic              busy_r;
    logic              overrun_r;

    assign frame_start_s = (state_r == ST_ADDR_A);
    assign commit_s      = (state_r == ST_COMMIT);
    assign tick_drop_s   = sample_tick && (state_r != ST_IDLE);
    assign addr_b_s      = wrap_add(base_s, ADDR_W'(OFFS_B));
    assign addr_c_s      = wrap_add(base_s, ADDR_W'(OFFS_C));

    phase_accum #(
        .LUT_DEPTH (LUT_DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_phase_accum (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start_s),
        .commit      (commit_s),
        .phase_rst   (phase_rst),
        .freq_step   (freq_step),
        .base        (base_s)
    );

    // Next-state logic; ticks only open a frame from IDLE while enabled.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (sample_tick && enable) begin
                    next_state_s = ST_ADDR_A;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ADDR_A: next_state_s = ST_ADDR_B;
            ST_ADDR_B: next_state_s = ST_ADDR_C;
            ST_ADDR_C: next_state_s = ST_COMMIT;
            ST_COMMIT: next_state_s = ST_IDLE;
            default:   next_state_s = ST_IDLE;
        endcase
    end

    // LUT port is decoded from the next state so it is registered yet valid in the issuing state.
    always_comb begin
        lut_addr_nxt_s  = lut_addr_r;
        lut_rd_en_nxt_s = 1'b0;
        case (next_state_s)
            ST_ADDR_A: begin
                lut_addr_nxt_s  = base_s;
                lut_rd_en_nxt_s = 1'b1;
            end
            ST_ADDR_B: begin
                lut_addr_nxt_s  = addr_b_s;
                lut_rd_en_nxt_s = 1'b1;
            end
            ST_ADDR_C: begin
                lut_addr_nxt_s  = addr_c_s;
                lut_rd_en_nxt_s = 1'b1;
            end
            default: begin
                lut_addr_nxt_s  = lut_addr_r;
                lut_rd_en_nxt_s = 1'b0;
            end
        endcase
    end

    // State, LUT port and busy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            lut_addr_r  <= {ADDR_W{1'b0}};
            lut_rd_en_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            lut_addr_r  <= lut_addr_nxt_s;
            lut_rd_en_r <= lut_rd_en_nxt_s;
            busy_r      <= (next_state_s != ST_IDLE);
        end
    end

    // Read data arrives one state after its address; park A and B until C lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_a_r <= {DATA_W{1'b0}};
            hold_b_r <= {DATA_W{1'b0}};
        end else if (state_r == ST_ADDR_B) begin
            hold_a_r <= lut_data;
            hold_b_r <= hold_b_r;
        end else if (state_r == ST_ADDR_C) begin
            hold_a_r <= hold_a_r;
            hold_b_r <= lut_data;
        end else begin
            hold_a_r <= hold_a_r;
            hold_b_r <= hold_b_r;
        end
    end

    // All three phases update on the same edge so the PWM never sees a mixed set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_a_r     <= {DATA_W{1'b0}};
            out_b_r     <= {DATA_W{1'b0}};
            out_c_r     <= {DATA_W{1'b0}};
            out_valid_r <= 1'b0;
        end else if (commit_s) begin
            out_a_r     <= hold_a_r;
            out_b_r     <= hold_b_r;
            out_c_r     <= lut_data;
            out_valid_r <= 1'b1;
        end else begin
            out_a_r     <= out_a_r;
            out_b_r     <= out_b_r;
            out_c_r     <= out_c_r;
            out_valid_r <= 1'b0;
        end
    end

    // Sticky overrun; a dropped tick wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_r <= 1'b0;
        end else if (tick_drop_s) begin
            overrun_r <= 1'b1;
        end else if (ovr_clr) begin
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    assign lut_addr  = lut_addr_r;
    assign lut_rd_en = lut_rd_en_r;
    assign out_a     = out_a_r;
    assign out_b     = out_b_r;
    assign out_c     = out_c_r;
    assign out_valid = out_valid_r;
    assign busy      = busy_r;
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_sine_lut_scheduler.sv
// Directed bench for sine_lut_scheduler: a frame-timeline model checked every
// cycle, plus hand-computed address and sample values for the key scenarios.
module tb_sine_lut_scheduler;

    localparam int DEPTH = 20000;
    localparam int OB    = 6667;
    localparam int OC    = 13333;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        sample_tick;
    logic [14:0] freq_step;
    logic        phase_rst;
    logic        ovr_clr;
    logic [14:0] lut_addr;
    logic        lut_rd_en;
    logic [7:0]  lut_data = 8'd0;
    logic [7:0]  out_a;
    logic [7:0]  out_b;
    logic [7:0]  out_c;
    logic        out_valid;
    logic        busy;
    logic        overrun;

    int n_chk  = 0;
    int n_fail = 0;

    // Model state: m_age counts cycles into the current frame (0 = no frame).
    int m_age, m_base, m_step, m_fbase;
    bit m_pend, m_ovr;
    int e_addr, e_a, e_b, e_c;
    bit e_rd, e_valid, e_busy;

    always #5 clk = ~clk;

    sine_lut_scheduler dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .sample_tick (sample_tick),
        .freq_step   (freq_step),
        .phase_rst   (phase_rst),
        .ovr_clr     (ovr_clr),
        .lut_addr    (lut_addr),
        .lut_rd_en   (lut_rd_en),
        .lut_data    (lut_data),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_c       (out_c),
        .out_valid   (out_valid),
        .busy        (busy),
        .overrun     (overrun)
    );

    function automatic logic [7:0] lut_fn(input int a);
        return 8'(a % 251);
    endfunction

    // Synchronous single-port LUT with one cycle of read latency.
    always @(posedge clk) begin
        if (lut_rd_en) lut_data <= lut_fn(int'(lut_addr));
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_age = 0; m_base = 0; m_step = 0; m_fbase = 0;
        m_pend = 0; m_ovr = 0;
        e_addr = 0; e_a = 0; e_b = 0; e_c = 0;
        e_rd = 0; e_valid = 0; e_busy = 0;
    endtask

    // Called just after a rising edge with the inputs that were applied during the cycle.
    task automatic model_step();
        int cur;
        int nxt;
        if (!rst_n) begin
            model_reset();
            return;
        end
        cur = m_age;
        if (sample_tick && cur != 0) m_ovr = 1;
        else if (ovr_clr) m_ovr = 0;
        if (cur == 1) m_step = (int'(freq_step) >= DEPTH) ? DEPTH - 1 : int'(freq_step);
        e_valid = 0;
        if (cur == 4) begin
            e_valid = 1;
            e_a = lut_fn(m_fbase);
            e_b = lut_fn((m_fbase + OB) % DEPTH);
            e_c = lut_fn((m_fbase + OC) % DEPTH);
            m_base = (m_pend || phase_rst) ? 0 : (m_base + m_step) % DEPTH;
            m_pend = 0;
        end else if (phase_rst) begin
            m_pend = 1;
        end
        if (cur == 0) nxt = (sample_tick && enable) ? 1 : 0;
        else          nxt = (cur == 4) ? 0 : cur + 1;
        if (nxt == 1) m_fbase = m_base;
        e_rd = (nxt >= 1 && nxt <= 3);
        if (e_rd) e_addr = (m_fbase + ((nxt == 1) ? 0 : (nxt == 2) ? OB : OC)) % DEPTH;
        e_busy = (nxt != 0);
        m_age  = nxt;
    endtask

    task automatic check_all();
        chk("lut_addr",  int'(lut_addr),  e_addr);
        chk("lut_rd_en", int'(lut_rd_en), int'(e_rd));
        chk("out_valid", int'(out_valid), int'(e_valid));
        chk("out_a",     int'(out_a),     e_a);
        chk("out_b",     int'(out_b),     e_b);
        chk("out_c",     int'(out_c),     e_c);
        chk("busy",      int'(busy),      int'(e_busy));
        chk("overrun",   int'(overrun),   int'(m_ovr));
    endtask

    // One clock cycle: inputs held across the rising edge, checks at the falling edge.
    task automatic cyc(input bit tick);
        sample_tick = tick;
        @(posedge clk);
        model_step();
        @(negedge clk);
        sample_tick = 1'b0;
        phase_rst   = 1'b0;
        ovr_clr     = 1'b0;
        check_all();
    endtask

    // One 5-cycle frame from a tick; returns the three issued addresses.
    task automatic frame(input int fs, input int ph_cyc, input int en_cyc,
                         output int a1, output int a2, output int a3);
        freq_step = 15'(fs);
        a1 = 0; a2 = 0; a3 = 0;
        for (int k = 0; k < 5; k++) begin
            if (k == ph_cyc) phase_rst = 1'b1;
            if (k == en_cyc) enable = 1'b0;
            cyc(k == 0);
            if (k == 0) a1 = int'(lut_addr);
            if (k == 1) a2 = int'(lut_addr);
            if (k == 2) a3 = int'(lut_addr);
        end
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_addr"},  int'(lut_addr),  0);
        chk({nm, "_rd"},    int'(lut_rd_en), 0);
        chk({nm, "_outs"},  int'({out_a, out_b, out_c}), 0);
        chk({nm, "_valid"}, int'(out_valid), 0);
        chk({nm, "_busy"},  int'(busy),      0);
        chk({nm, "_ovr"},   int'(overrun),   0);
    endtask

    initial begin
        int a1, a2, a3;
        rst_n = 1'b0; enable = 1'b1; sample_tick = 1'b0; freq_step = 15'd0;
        phase_rst = 1'b0; ovr_clr = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;
        cyc(1'b0);

        // First frame from reset, step 1
        frame(1, -1, -1, a1, a2, a3);
        chk("f1_a1", a1, 0); chk("f1_a2", a2, 6667); chk("f1_a3", a3, 13333);
        chk("f1_valid", int'(out_valid), 1);
        chk("f1_out_a", int'(out_a), 0); chk("f1_out_b", int'(out_b), 141); chk("f1_out_c", int'(out_c), 30);
        frame(13332, -1, -1, a1, a2, a3);
        chk("f2_base", a1, 1);

        // Offset wrap from base 13333, then base 19999 + 1 -> 0
        frame(6666, -1, -1, a1, a2, a3);
        chk("wrap_a1", a1, 13333); chk("wrap_a2", a2, 0); chk("wrap_a3", a3, 6666);
        frame(1, -1, -1, a1, a2, a3);
        chk("b19999_a1", a1, 19999); chk("b19999_a2", a2, 6666); chk("b19999_a3", a3, 13332);
        frame(19995, -1, -1, a1, a2, a3);
        chk("b0_after_wrap", a1, 0);
        frame(7, -1, -1, a1, a2, a3);
        chk("b19995", a1, 19995);
        frame(25000, -1, -1, a1, a2, a3);
        chk("step_wrap", a1, 2);
        frame(0, -1, -1, a1, a2, a3);
        chk("step_sat", a1, 1);
        frame(0, -1, -1, a1, a2, a3);
        chk("step_zero", a1, 1);

        // Overrun: ticks at cycles 0 and 3
        freq_step = 15'd0;
        cyc(1'b1); cyc(1'b0); cyc(1'b0); cyc(1'b1); cyc(1'b0);
        chk("ovr_valid", int'(out_valid), 1);
        chk("ovr_set", int'(overrun), 1);
        cyc(1'b0);
        chk("ovr_single_valid", int'(out_valid), 0);
        ovr_clr = 1'b1;
        cyc(1'b0);
        chk("ovr_clr", int'(overrun), 0);
        frame(0, -1, -1, a1, a2, a3);
        frame(0, -1, -1, a1, a2, a3);
        chk("spaced_no_ovr", int'(overrun), 0);

        // phase_rst mid-frame, then the following frame starts at 0
        frame(100, 2, -1, a1, a2, a3);
        frame(5, -1, -1, a1, a2, a3);
        chk("prst_a1", a1, 0); chk("prst_a2", a2, 6667); chk("prst_a3", a3, 13333);

        // enable dropped at ADDR_B
        frame(5, -1, 2, a1, a2, a3);
        chk("en_drop_valid", int'(out_valid), 1);
        cyc(1'b1); cyc(1'b0); cyc(1'b1); cyc(1'b0);
        chk("en_off_busy", int'(busy), 0);
        chk("en_off_ovr", int'(overrun), 0);
        enable = 1'b1;
        frame(3, -1, -1, a1, a2, a3);
        chk("en_resume_base", a1, 10);

        // Reset during ADDR_C
        cyc(1'b1); cyc(1'b0); cyc(1'b0);
        chk("pre_rst_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        model_reset();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        cyc(1'b0);
        chk("midrst_no_valid", int'(out_valid), 0);
        frame(2, -1, -1, a1, a2, a3);
        chk("post_rst_a1", a1, 0);
        chk("post_rst_valid", int'(out_valid), 1);
        cyc(1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
